// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } tow_state_t;

  function automatic int ctr_idx(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_of_war_field_if.sv
// Player/display bundle of the tug-of-war playfield; master drives buttons, slave is the field.
interface tug_of_war_field_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);

  logic                  l_btn;
  logic                  r_btn;
  logic                  new_round;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  win_l;
  logic                  win_r;
  logic [SCORE_W-1:0]    score_l;
  logic [SCORE_W-1:0]    score_r;

  modport master (
    output l_btn, r_btn, new_round,
    input  lights, win_l, win_r, score_l, score_r
  );

  modport slave (
    input  l_btn, r_btn, new_round,
    output lights, win_l, win_r, score_l, score_r
  );

endinterface

// File: rtl/tow_press_detect.sv
// Rising-edge press detector; history resets high so a button held through reset is not a press.
module tow_press_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic hist_d;
  logic hist_q;

  // Next history value is simply the current button level.
  always_comb begin
    hist_d = btn;
  end

  // Button history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign press = btn & ~hist_q;

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: position counter, round FSM and one-hot LED bar.
// Optional win counters are built when TOW_SCORE_EN is defined; otherwise scores read 0.
module tug_of_war_field
  import tow_pkg::*;
#(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  tug_of_war_field_if.slave  bus
);

  localparam int                    POS_W      = $clog2(NUM_LIGHTS);
  localparam int                    CTR        = ctr_idx(NUM_LIGHTS);
  localparam logic [POS_W-1:0]      POS_CTR    = POS_W'(CTR);
  localparam logic [POS_W-1:0]      POS_MAX    = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]      POS_ONE    = POS_W'(1'b1);
  localparam logic [NUM_LIGHTS-1:0] LIGHT_ONE  = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LIGHTS-1:0] LIGHTS_CTR = LIGHT_ONE << CTR;

  logic                  l_press_s;
  logic                  r_press_s;
  tow_state_t            state_d;
  tow_state_t            state_q;
  logic [POS_W-1:0]      pos_d;
  logic [POS_W-1:0]      pos_q;
  logic [NUM_LIGHTS-1:0] lights_d;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic                  win_l_d;
  logic                  win_l_q;
  logic                  win_r_d;
  logic                  win_r_q;

  tow_press_detect u_l_press (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.l_btn),
    .press (l_press_s)
  );

  tow_press_detect u_r_press (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.r_btn),
    .press (r_press_s)
  );

  // Round FSM and position update; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      PLAY: begin
        if (l_press_s && !r_press_s) begin
          if (pos_q == POS_MAX) begin
            state_d = WIN_L;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end else if (r_press_s && !l_press_s) begin
          if (pos_q == '0) begin
            state_d = WIN_R;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end else begin
          pos_d = pos_q;
        end
      end
      WIN_L, WIN_R: begin
        if (bus.new_round) begin
          state_d = PLAY;
          pos_d   = POS_CTR;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = PLAY;
        pos_d   = POS_CTR;
      end
    endcase

    lights_d = (state_d == PLAY) ? (LIGHT_ONE << pos_d) : '0;
    win_l_d  = (state_d == WIN_L) ? 1'b1 : 1'b0;
    win_r_d  = (state_d == WIN_R) ? 1'b1 : 1'b0;
  end

  // FSM, position and display registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PLAY;
      pos_q    <= POS_CTR;
      lights_q <= LIGHTS_CTR;
      win_l_q  <= 1'b0;
      win_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      lights_q <= lights_d;
      win_l_q  <= win_l_d;
      win_r_q  <= win_r_d;
    end
  end

  assign bus.lights = lights_q;
  assign bus.win_l  = win_l_q;
  assign bus.win_r  = win_r_q;

`ifdef TOW_SCORE_EN
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1'b1);

  logic [SCORE_W-1:0] score_l_d;
  logic [SCORE_W-1:0] score_l_q;
  logic [SCORE_W-1:0] score_r_d;
  logic [SCORE_W-1:0] score_r_q;

  // Count a win once, on the PLAY-to-WIN transition, saturating at the maximum.
  always_comb begin
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (state_q == PLAY && state_d == WIN_L && score_l_q != SCORE_MAX) begin
      score_l_d = score_l_q + SCORE_ONE;
    end else begin
      score_l_d = score_l_q;
    end
    if (state_q == PLAY && state_d == WIN_R && score_r_q != SCORE_MAX) begin
      score_r_d = score_r_q + SCORE_ONE;
    end else begin
      score_r_d = score_r_q;
    end
  end

  // Win counters; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;
`else
  assign bus.score_l = {SCORE_W{1'b0}};
  assign bus.score_r = {SCORE_W{1'b0}};
`endif

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed bench for tug_of_war_field (NUM_LIGHTS=9, SCORE_W=3); score expectations follow TOW_SCORE_EN.
module tb_tug_of_war_field;

  localparam int NL = 9;
  localparam int SW = 3;

`ifdef TOW_SCORE_EN
  localparam int SCORE_ON = 1;
`else
  localparam int SCORE_ON = 0;
`endif

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  tug_of_war_field_if #(.NUM_LIGHTS(NL), .SCORE_W(SW)) bus ();

  tug_of_war_field #(.NUM_LIGHTS(NL), .SCORE_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic press_l();
    bus.l_btn = 1'b1;
    @(negedge clk);
    bus.l_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_r();
    bus.r_btn = 1'b1;
    @(negedge clk);
    bus.r_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_new_round();
    bus.new_round = 1'b1;
    @(negedge clk);
    bus.new_round = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    reset         = 1'b0;
    bus.l_btn     = 1'b0;
    bus.r_btn     = 1'b0;
    bus.new_round = 1'b0;

    // 1: reset values
    repeat (2) @(negedge clk);
    chk("rst_lights_held", 32'(bus.lights), 32'h010);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_lights", 32'(bus.lights), 32'h010);
    chk("rst_win_l", 32'(bus.win_l), 32'h0);
    chk("rst_win_r", 32'(bus.win_r), 32'h0);
    chk("rst_score_l", 32'(bus.score_l), 32'h0);
    chk("rst_score_r", 32'(bus.score_r), 32'h0);

    // 2: held left button moves exactly once
    bus.l_btn = 1'b1;
    @(negedge clk);
    chk("hold_first_move", 32'(bus.lights), 32'h020);
    repeat (4) @(negedge clk);
    bus.l_btn = 1'b0;
    @(negedge clk);
    chk("hold_one_move", 32'(bus.lights), 32'h020);

    // 3: simultaneous rise is a tie
    bus.l_btn = 1'b1;
    bus.r_btn = 1'b1;
    @(negedge clk);
    chk("tie_no_move", 32'(bus.lights), 32'h020);
    bus.l_btn = 1'b0;
    bus.r_btn = 1'b0;
    @(negedge clk);

    // new_round has no effect during play
    pulse_new_round();
    chk("new_round_in_play", 32'(bus.lights), 32'h020);

    // back to centre, then walk left to the end and win
    press_r();
    chk("back_to_ctr", 32'(bus.lights), 32'h010);
    press_l();
    press_l();
    press_l();
    chk("pos_7", 32'(bus.lights), 32'h080);
    press_l();
    chk("pos_8_edge", 32'(bus.lights), 32'h100);
    chk("no_win_at_edge", 32'(bus.win_l), 32'h0);
    press_l();
    chk("win_l_lights", 32'(bus.lights), 32'h000);
    chk("win_l_flag", 32'(bus.win_l), 32'h1);
    chk("win_l_score", 32'(bus.score_l), 32'(SCORE_ON));
    press_l();
    press_r();
    chk("win_frozen_lights", 32'(bus.lights), 32'h000);
    chk("win_frozen_win_l", 32'(bus.win_l), 32'h1);
    chk("win_frozen_win_r", 32'(bus.win_r), 32'h0);
    chk("win_frozen_score", 32'(bus.score_l), 32'(SCORE_ON));

    // 5: next round
    pulse_new_round();
    chk("nr_lights", 32'(bus.lights), 32'h010);
    chk("nr_win_l", 32'(bus.win_l), 32'h0);
    chk("nr_score_kept", 32'(bus.score_l), 32'(SCORE_ON));

    // right player win from centre takes five presses
    for (int i = 0; i < 5; i++) press_r();
    chk("win_r_lights", 32'(bus.lights), 32'h000);
    chk("win_r_flag", 32'(bus.win_r), 32'h1);
    chk("win_r_score", 32'(bus.score_r), 32'(SCORE_ON));
    pulse_new_round();
    chk("nr2_win_r", 32'(bus.win_r), 32'h0);

    // seven more left wins; score saturates at 7
    for (int w = 2; w <= 8; w++) begin
      for (int i = 0; i < 5; i++) press_l();
      chk("sat_win_l", 32'(bus.win_l), 32'h1);
      chk("sat_score_l", 32'(bus.score_l), 32'((SCORE_ON != 0) ? ((w > 7) ? 7 : w) : 0));
      pulse_new_round();
    end
    chk("sat_score_r_kept", 32'(bus.score_r), 32'(SCORE_ON));

    // 6: async reset mid-round at pos 2
    press_r();
    press_r();
    chk("pos_2", 32'(bus.lights), 32'h004);
    #2;
    reset = 1'b0;
    #1;
    chk("async_lights", 32'(bus.lights), 32'h010);
    chk("async_score_l", 32'(bus.score_l), 32'h0);
    chk("async_score_r", 32'(bus.score_r), 32'h0);

    // button held through reset release is not a press
    bus.l_btn = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("held_thru_reset", 32'(bus.lights), 32'h010);
    bus.l_btn = 1'b0;
    @(negedge clk);
    press_l();
    chk("after_reset_move", 32'(bus.lights), 32'h020);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
